// File: rtl/cnt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cnt_pkg : shared encodings for the counter sequencer                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cnt_pkg;

    localparam int CNT_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_OVFLW   = 2'b01,
        RSP_TIMEOUT = 2'b10,
        RSP_ABORT   = 2'b11
    } rsp_status_t;

endpackage
`default_nettype wire

// File: rtl/cnt_dir_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cnt_dir_sel : picks counter direction toward a target value           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cnt_dir_sel
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] target,
    input  logic             wrap_ok,
    output logic             up
);

    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] dist_up;

    // Modular distance going up; a tie at exactly half the range goes up.
    assign dist_up = target - count;
    assign up      = wrap_ok ? (dist_up <= HALF) : (target > count);

endmodule
`default_nettype wire

// File: rtl/cnt_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cnt_seq : drives an external up/down counter to a commanded target    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cnt_seq
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_wrap_ok,
    input  logic             abort,
    input  logic [WIDTH-1:0] count,
    input  logic             ovflw,
    output logic             act,
    output logic             up_dwn_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic [WIDTH:0]   rsp_steps
);

    localparam logic [WIDTH:0] STEP_LIMIT = {1'b1, {WIDTH{1'b0}}};

    state_t           state_q,   state_d;
    rsp_status_t      status_q,  status_d;
    logic [WIDTH-1:0] target_q,  target_d;
    logic             wrap_ok_q, wrap_ok_d;
    logic             dir_q,     dir_d;
    logic [WIDTH:0]   steps_q,   steps_d;

    logic dir_up;
    logic hit;
    logic ovf_err;
    logic timed_out;
    logic act_w;

    cnt_dir_sel #(
        .WIDTH (WIDTH)
    ) u_dir_sel (
        .count   (count),
        .target  (target_q),
        .wrap_ok (wrap_ok_q),
        .up      (dir_up)
    );

    assign hit       = (count == target_q);
    assign ovf_err   = ovflw & ~wrap_ok_q;
    assign timed_out = (steps_q == STEP_LIMIT);
    // Any terminating condition suppresses the step in the same cycle.
    assign act_w     = (state_q == ST_RUN) & ~hit & ~abort & ~ovf_err & ~timed_out;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        target_d  = target_q;
        wrap_ok_d = wrap_ok_q;
        dir_d     = dir_q;
        steps_d   = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_d  = cmd_target;
                    wrap_ok_d = cmd_wrap_ok;
                    steps_d   = '0;
                    state_d   = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (hit) begin
                    status_d = RSP_OK;
                    state_d  = ST_RESP;
                end else begin
                    dir_d   = dir_up;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    status_d = RSP_ABORT;
                    state_d  = ST_RESP;
                end else if (ovf_err) begin
                    status_d = RSP_OVFLW;
                    state_d  = ST_RESP;
                end else if (hit) begin
                    status_d = RSP_OK;
                    state_d  = ST_RESP;
                end else if (timed_out) begin
                    status_d = RSP_TIMEOUT;
                    state_d  = ST_RESP;
                end else begin
                    steps_d = steps_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            status_q  <= RSP_OK;
            target_q  <= '0;
            wrap_ok_q <= 1'b0;
            dir_q     <= 1'b1;
            steps_q   <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            target_q  <= target_d;
            wrap_ok_q <= wrap_ok_d;
            dir_q     <= dir_d;
            steps_q   <= steps_d;
        end
    end

    assign act        = act_w;
    assign up_dwn_n   = (state_q == ST_RUN) ? dir_q : 1'b1;
    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_status = status_q;
    assign rsp_steps  = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cnt_seq : bench for cnt_seq with a behavioural up/down counter     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_cnt_seq;

    localparam int         W      = 5;
    localparam int         NONE   = 99;
    localparam logic [1:0] S_OK   = 2'b00;
    localparam logic [1:0] S_OVF  = 2'b01;
    localparam logic [1:0] S_TO   = 2'b10;
    localparam logic [1:0] S_ABT  = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_target;
    logic         cmd_wrap_ok;
    logic         abort;
    logic [W-1:0] count;
    logic         ovflw;
    logic         act;
    logic         up_dwn_n;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_status;
    logic [W:0]   rsp_steps;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural up/down counter the sequencer is paired with.
    logic [W-1:0] cnt_q     = '0;
    logic         wrap_flag = 1'b0;
    int           act_cnt   = 0;
    logic         load_en   = 1'b0;
    logic [W-1:0] load_val  = '0;
    logic         freeze    = 1'b0;
    logic         force_ovf = 1'b0;

    assign count = cnt_q;
    assign ovflw = wrap_flag | force_ovf;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            cnt_q     <= load_val;
            wrap_flag <= 1'b0;
            act_cnt   <= 0;
        end else if (act) begin
            act_cnt <= act_cnt + 1;
            if (!freeze) begin
                cnt_q     <= up_dwn_n ? cnt_q + 1'b1 : cnt_q - 1'b1;
                wrap_flag <= up_dwn_n ? (cnt_q == '1) : (cnt_q == '0);
            end else begin
                wrap_flag <= 1'b0;
            end
        end else begin
            wrap_flag <= 1'b0;
        end
    end

    cnt_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_wrap_ok (cmd_wrap_ok),
        .abort       (abort),
        .count       (count),
        .ovflw       (ovflw),
        .act         (act),
        .up_dwn_n    (up_dwn_n),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_steps   (rsp_steps)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: shortest/direct distance, then first terminating event wins.
    task automatic ref_model(input logic [W-1:0] c, input logic [W-1:0] t, input logic w,
                             input int ka, input int ko, input logic fz,
                             output logic [1:0] es, output int esteps,
                             output logic [W-1:0] efin, output logic eup);
        int dup, ddn, n, s, ko_eff;
        dup = (int'(t) - int'(c) + 32) % 32;
        ddn = (int'(c) - int'(t) + 32) % 32;
        eup = w ? (dup <= 16) : (t > c);
        if (c == t) begin
            es = S_OK; esteps = 0; efin = c;
        end else begin
            n      = fz ? 1000 : (eup ? dup : ddn);
            ko_eff = w ? 1000 : ko;
            s = 32;
            if (n < s)      s = n;
            if (ka < s)     s = ka;
            if (ko_eff < s) s = ko_eff;
            if (ka == s)          es = S_ABT;
            else if (ko_eff == s) es = S_OVF;
            else if (n == s)      es = S_OK;
            else                  es = S_TO;
            esteps = s;
            efin   = fz ? c : (eup ? c + W'(s) : c - W'(s));
        end
    endtask

    task automatic run_cmd(input string name, input logic [W-1:0] c, input logic [W-1:0] t,
                           input logic w, input int ka, input int ko, input logic fz,
                           input int hold, input logic [1:0] es, input int esteps,
                           input logic [W-1:0] efin, input logic eup);
        logic done;
        logic dir_bad;
        @(negedge clk);
        load_val = c; freeze = fz; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        check({name, " cmd_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_target = t; cmd_wrap_ok = w;
        @(negedge clk);
        cmd_valid = 1'b0;
        done = 1'b0; dir_bad = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            abort     = (act_cnt == ka);
            force_ovf = (act_cnt == ko);
            #1;
            if (act && (up_dwn_n !== eup)) dir_bad = 1'b1;
            if (rsp_valid) done = 1'b1;
            else @(negedge clk);
        end
        abort = 1'b0; force_ovf = 1'b0;
        check({name, " rsp_arrived"}, int'(done), 1);
        check({name, " status"}, int'(rsp_status), int'(es));
        check({name, " steps"}, int'(rsp_steps), esteps);
        check({name, " act_cycles"}, act_cnt, esteps);
        check({name, " final_count"}, int'(cnt_q), int'(efin));
        check({name, " direction"}, int'(dir_bad), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, " held"}, int'(rsp_valid && rsp_status == es && rsp_steps == esteps
                                        && !act), 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, " released"}, int'(cmd_ready && !rsp_valid), 1);
    endtask

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] t;
        logic         w;
        int           ka;
        int           ko;
        logic         fz;
        int           hold;
        logic [1:0]   es;
        int           esteps;
        logic [W-1:0] efin;
        logic         eup;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [1:0]   r_es;
        int           r_steps;
        logic [W-1:0] r_fin;
        logic         r_up;
        logic [W-1:0] rc, rt;
        logic         rw, rfz;
        int           rka, rko;
        logic         got_rsp;

        vecs[0]  = '{5'd0,  5'd4,  1'b0, NONE, NONE, 1'b0, 0, S_OK,  4,  5'd4,  1'b1};
        vecs[1]  = '{5'd4,  5'd30, 1'b1, NONE, NONE, 1'b0, 0, S_OK,  6,  5'd30, 1'b0};
        vecs[2]  = '{5'd4,  5'd30, 1'b0, NONE, NONE, 1'b0, 0, S_OK,  26, 5'd30, 1'b1};
        vecs[3]  = '{5'd4,  5'd30, 1'b0, NONE, 3,    1'b0, 0, S_OVF, 3,  5'd7,  1'b1};
        vecs[4]  = '{5'd0,  5'd9,  1'b0, NONE, NONE, 1'b1, 0, S_TO,  32, 5'd0,  1'b1};
        vecs[5]  = '{5'd10, 5'd20, 1'b0, 2,    NONE, 1'b0, 5, S_ABT, 2,  5'd12, 1'b1};
        vecs[6]  = '{5'd7,  5'd7,  1'b1, NONE, NONE, 1'b0, 1, S_OK,  0,  5'd7,  1'b1};
        vecs[7]  = '{5'd31, 5'd0,  1'b1, NONE, NONE, 1'b0, 0, S_OK,  1,  5'd0,  1'b1};
        vecs[8]  = '{5'd0,  5'd16, 1'b1, NONE, NONE, 1'b0, 0, S_OK,  16, 5'd16, 1'b1};
        vecs[9]  = '{5'd0,  5'd17, 1'b1, NONE, NONE, 1'b0, 0, S_OK,  15, 5'd17, 1'b0};
        vecs[10] = '{5'd5,  5'd9,  1'b1, NONE, 2,    1'b0, 0, S_OK,  4,  5'd9,  1'b1};
        vecs[11] = '{5'd3,  5'd5,  1'b0, 2,    NONE, 1'b0, 0, S_ABT, 2,  5'd5,  1'b1};
        vecs[12] = '{5'd3,  5'd5,  1'b0, 0,    NONE, 1'b0, 0, S_ABT, 0,  5'd3,  1'b1};
        vecs[13] = '{5'd20, 5'd10, 1'b0, 3,    3,    1'b0, 0, S_ABT, 3,  5'd17, 1'b0};
        vecs[14] = '{5'd30, 5'd4,  1'b0, NONE, 0,    1'b0, 0, S_OVF, 0,  5'd30, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_wrap_ok = 1'b0;
        abort = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset outputs", int'({act, up_dwn_n, rsp_valid, cmd_ready}), int'(4'b0101));
        check("reset rsp", int'({rsp_status, rsp_steps}), 0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_cmd($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].w, vecs[i].ka,
                    vecs[i].ko, vecs[i].fz, vecs[i].hold, vecs[i].es, vecs[i].esteps,
                    vecs[i].efin, vecs[i].eup);

        // Reset pulsed in the middle of a run: act drops at once, no response.
        @(negedge clk);
        load_val = 5'd0; freeze = 1'b0; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        cmd_valid = 1'b1; cmd_target = 5'd20; cmd_wrap_ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && act_cnt < 3; i++) @(negedge clk);
        check("midrun act before reset", int'(act), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset outputs", int'({act, up_dwn_n, rsp_valid, cmd_ready}),
              int'(4'b0101));
        @(negedge clk);
        rst_n = 1'b1;
        got_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || act) got_rsp = 1'b1;
        end
        check("no rsp after reset", int'(got_rsp), 0);
        run_cmd("post_reset", 5'd0, 5'd2, 1'b0, NONE, NONE, 1'b0, 0, S_OK, 2, 5'd2, 1'b1);

        for (int k = 0; k < 40; k++) begin
            rc  = W'($urandom_range(0, 31));
            rt  = W'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            rfz = ($urandom_range(0, 9) == 0);
            rka = ($urandom_range(0, 1) == 0) ? NONE : int'($urandom_range(0, 33));
            rko = ($urandom_range(0, 1) == 0) ? NONE : int'($urandom_range(0, 33));
            ref_model(rc, rt, rw, rka, rko, rfz, r_es, r_steps, r_fin, r_up);
            run_cmd($sformatf("rnd%0d", k), rc, rt, rw, rka, rko, rfz,
                    int'($urandom_range(0, 3)), r_es, r_steps, r_fin, r_up);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnt_seq.md
CNT_SEQ -- requirements
Module: cnt_seq

Interface
REQ-001 Parameter WIDTH, default 5: width of counter value, cmd_target and rsp_steps LSBs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block accepts a command; high only in IDLE.
REQ-006 cmd_target  input  WIDTH  target counter value.
REQ-007 cmd_wrap_ok  input  1  1 = shortest path with wrap allowed; 0 = direct path, wrap is an error.
REQ-008 abort  input  1  terminate the running command.
REQ-009 count  input  WIDTH  current value from the up/down counter.
REQ-010 ovflw  input  1  counter wrap indication from the counter.
REQ-011 act  output  1  counter enable; the counter steps ±1 on each rising edge with act=1.
REQ-012 up_dwn_n  output  1  counter direction: 1 = up, 0 = down.
REQ-013 rsp_valid  output  1  response available; held until accepted.
REQ-014 rsp_ready  input  1  response accepted when rsp_valid and rsp_ready are both 1.
REQ-015 rsp_status  output  2  00 OK, 01 OVFLW, 10 TIMEOUT, 11 ABORT.
REQ-016 rsp_steps  output  WIDTH+1  number of act-high cycles spent on the command.

Function
REQ-017 The FSM SHALL have states IDLE, DECIDE, RUN and RESP.
REQ-018 IDLE: on a cycle with cmd_valid and cmd_ready both 1, latch cmd_target and cmd_wrap_ok, clear the step counter, and go to DECIDE.
REQ-019 DECIDE (exactly 1 cycle): if count == target, go to RESP with status OK and steps 0; otherwise latch the direction and go to RUN.
REQ-020 Direction, wrap_ok=0: up if target > count, else down (unsigned compare).
REQ-021 Direction, wrap_ok=1: d = (target - count) mod 2^WIDTH; up if d <= 2^(WIDTH-1), else down.
REQ-022 act SHALL be combinational: act = RUN and count != target and no terminating condition in the current cycle; up_dwn_n is the latched direction, and 1 outside RUN.
REQ-023 RUN: the step counter increments on each cycle with act=1.
REQ-024 RUN terminating conditions, in priority order:
  - abort -> ABORT
  - ovflw with wrap_ok=0 -> OVFLW
  - count == target -> OK
  - steps == 2^WIDTH -> TIMEOUT
REQ-025 On the terminating condition, latch status and steps, and go to RESP in the same edge; act is 0 in that cycle, so no extra counter step occurs.
REQ-026 ovflw with wrap_ok=1 SHALL be ignored.
REQ-027 RESP: rsp_valid=1 with stable status and steps; on rsp_ready go to IDLE. abort is ignored outside RUN.
REQ-028 cmd_ready SHALL be 1 only in IDLE, giving back-to-back commands a minimum spacing of 3 cycles.

Reset
REQ-029 While rst_n=0, all state SHALL clear immediately: state IDLE, act 0, up_dwn_n 1, rsp_valid 0, rsp_status 00, rsp_steps 0, cmd_ready 1.
REQ-030 A reset asserted during RUN SHALL drop act asynchronously; the in-flight command is discarded with no response.

Structure
REQ-031 The shared package cnt_pkg SHALL hold the state encodings (2 bits), the rsp_status codes and the default WIDTH.
REQ-032 Direction selection (REQ-020/021) SHALL be a combinational sub-module cnt_dir_sel (inputs count, target, wrap_ok; output up).
REQ-033 Verification SHALL pair cnt_seq with the team's up/down counter instance or a behavioural model with identical stepping.

Verification (WIDTH=5)
REQ-034 count=0, target=4, wrap_ok=0 -> act high 4 cycles, up_dwn_n=1, final count 4, status OK, steps 4.
REQ-035 count=4, target=30, wrap_ok=1 -> down through wrap 4..0,31,30; ovflw ignored; 6 steps; status OK.
REQ-036 Same start and target with wrap_ok=0 -> up, 26 steps, status OK; a separate run with ovflw forced at step 3 -> status OVFLW, steps 3, counter stops.
REQ-037 Counter frozen at 0, target=9 -> act high 32 cycles, status TIMEOUT, steps 32.
REQ-038 abort at step 2 -> act low that cycle, status ABORT, steps 2; rsp_valid held through 5 cycles with rsp_ready=0, then released.
REQ-039 rst_n pulsed low mid-RUN -> act 0 immediately, no response, cmd_ready=1 after release; next command count=0 to target=2 completes OK.
